// File: rtl/puzzle4_pkg.sv
// Shared types and helpers for the iterative paper-roll removal solver.
package puzzle4_pkg;

  // A roll survives only with at least this many occupied neighbours
  localparam int unsigned NEIGH_THRESH = 4;

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    CHECK,
    DONE
  } state_t;

  function automatic int unsigned words_per_row(input int unsigned row_size,
                                                input int unsigned mod_size);
    return (row_size + mod_size - 1) / mod_size;
  endfunction

  function automatic int unsigned padded_width(input int unsigned row_size,
                                               input int unsigned mod_size);
    return words_per_row(row_size, mod_size) * mod_size;
  endfunction

endpackage

// File: rtl/row_remover.sv
// Combinational removal of one grid row given its two vertical neighbours.
module row_remover
  import puzzle4_pkg::*;
#(
  parameter int unsigned ROW_SIZE = 139,
  parameter int unsigned CNT_W    = $clog2(ROW_SIZE + 1)
) (
  input  logic [ROW_SIZE-1:0] row_above,
  input  logic [ROW_SIZE-1:0] row_cur,
  input  logic [ROW_SIZE-1:0] row_below,
  output logic [ROW_SIZE-1:0] new_row,
  output logic [CNT_W-1:0]    removed_count
);

  localparam int unsigned PW = ROW_SIZE + 2;

  // Zero-pad both ends so edge columns see empty cells; column c sits at bit c+1
  logic [PW-1:0]       pad_above;
  logic [PW-1:0]       pad_cur;
  logic [PW-1:0]       pad_below;
  logic [ROW_SIZE-1:0] mask;

  assign pad_above = {1'b0, row_above, 1'b0};
  assign pad_cur   = {1'b0, row_cur, 1'b0};
  assign pad_below = {1'b0, row_below, 1'b0};

  genvar c;
  generate
    for (c = 0; c < ROW_SIZE; c++) begin : g_col
      logic [3:0] cnt;
      assign cnt = 4'(pad_above[c]) + 4'(pad_above[c+1]) + 4'(pad_above[c+2])
                 + 4'(pad_cur[c])                        + 4'(pad_cur[c+2])
                 + 4'(pad_below[c]) + 4'(pad_below[c+1]) + 4'(pad_below[c+2]);
      assign mask[c] = row_cur[c] & (cnt < 4'(NEIGH_THRESH));
    end
  endgenerate

  assign new_row = row_cur & ~mask;

  always_comb begin
    removed_count = '0;
    for (int i = 0; i < ROW_SIZE; i++) begin
      removed_count = removed_count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/puzzle4_part2.sv
// Loads a square roll grid from a word stream, then sweeps row by row removing
// accessible rolls until a full pass changes nothing; reports the total removed.
module puzzle4_part2
  import puzzle4_pkg::*;
#(
  parameter int unsigned ROW_SIZE     = 139,
  parameter int unsigned MODULAR_SIZE = 32,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    top_enable,
  input  logic [MODULAR_SIZE-1:0] in_data_top,
  output logic [OUTPUT_WIDTH-1:0] out_sum,
  output logic                    done
);

  localparam int unsigned WORDS_PER_ROW = words_per_row(ROW_SIZE, MODULAR_SIZE);
  localparam int unsigned PADDED        = padded_width(ROW_SIZE, MODULAR_SIZE);
  localparam int unsigned RCW           = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned WCW           = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned CNT_W         = $clog2(ROW_SIZE + 1);

  state_t state, state_next;

  logic [ROW_SIZE-1:0] grid [ROW_SIZE];
  logic [RCW-1:0]      row_cnt;
  logic [WCW-1:0]      word_cnt;
  logic                pass_changed;

  logic                row_last;
  logic                word_last;
  logic [ROW_SIZE-1:0] ld_row;
  logic [ROW_SIZE-1:0] row_above;
  logic [ROW_SIZE-1:0] row_below;
  logic [ROW_SIZE-1:0] new_row;
  logic [CNT_W-1:0]    removed_count;

  assign row_last  = (row_cnt == RCW'(ROW_SIZE - 1));
  assign word_last = (word_cnt == WCW'(WORDS_PER_ROW - 1));

  // Merge the incoming word into the current row; padding columns never map here
  genvar c;
  generate
    for (c = 0; c < ROW_SIZE; c++) begin : g_ld
      assign ld_row[c] = (word_cnt == WCW'(c / MODULAR_SIZE))
                       ? in_data_top[(PADDED - 1 - c) % MODULAR_SIZE]
                       : grid[row_cnt][c];
    end
  endgenerate

  assign row_above = (row_cnt == '0) ? '0 : grid[row_cnt - RCW'(1)];
  assign row_below = row_last        ? '0 : grid[row_cnt + RCW'(1)];

  row_remover #(
    .ROW_SIZE (ROW_SIZE),
    .CNT_W    (CNT_W)
  ) u_row_remover (
    .row_above     (row_above),
    .row_cur       (grid[row_cnt]),
    .row_below     (row_below),
    .new_row       (new_row),
    .removed_count (removed_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (top_enable && word_last && row_last) state_next = SCAN;
      SCAN:    if (row_last) state_next = CHECK;
      CHECK:   state_next = pass_changed ? SCAN : DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Grid storage, counters and accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROW_SIZE; i++) grid[i] <= '0;
      row_cnt      <= '0;
      word_cnt     <= '0;
      pass_changed <= 1'b0;
      out_sum      <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (top_enable) begin
            grid[row_cnt] <= ld_row;
            if (word_last) begin
              word_cnt <= '0;
              row_cnt  <= row_last ? '0 : row_cnt + RCW'(1);
            end else begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
        SCAN: begin
          grid[row_cnt] <= new_row;
          out_sum       <= out_sum + OUTPUT_WIDTH'(removed_count);
          if (removed_count != '0) pass_changed <= 1'b1;
          row_cnt       <= row_last ? '0 : row_cnt + RCW'(1);
        end
        CHECK: begin
          pass_changed <= 1'b0;
          row_cnt      <= '0;
          if (!pass_changed) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle4_part2.sv
// Directed bench: a 10x10 instance for the worked example and a default-size
// instance for empty, full, block and stalled-stream grids.
module tb_puzzle4_part2;

  localparam int unsigned SR   = 10;
  localparam int unsigned LR   = 139;
  localparam int unsigned M    = 32;
  localparam int unsigned OW   = 16;
  localparam int unsigned LWPR = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_en, l_en;
  logic [M-1:0]  s_data, l_data;
  logic [OW-1:0] s_sum, l_sum;
  logic          s_done, l_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int ncyc;

  logic [SR-1:0] small_rows [SR];

  always #5 clk = ~clk;

  puzzle4_part2 #(.ROW_SIZE(SR), .MODULAR_SIZE(M), .OUTPUT_WIDTH(OW)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .top_enable  (s_en),
    .in_data_top (s_data),
    .out_sum     (s_sum),
    .done        (s_done)
  );

  puzzle4_part2 dut_l (
    .clk         (clk),
    .reset       (reset),
    .top_enable  (l_en),
    .in_data_top (l_data),
    .out_sum     (l_sum),
    .done        (l_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pattern 0: empty, 1: all ones (padding zero), 2: 2x2 block at rows 50-51 cols 60-61
  function automatic logic [M-1:0] large_word(input int pattern, input int r, input int w);
    case (pattern)
      1:       return (w == 4) ? 32'hFFE0_0000 : 32'hFFFF_FFFF;
      2:       return ((r == 50 || r == 51) && w == 1) ? 32'h0000_000C : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_reset();
    reset  = 1'b0;
    s_en   = 1'b0;
    l_en   = 1'b0;
    s_data = '0;
    l_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic load_small();
    for (int r = 0; r < SR; r++) begin
      s_en   = 1'b1;
      s_data = {small_rows[r], 22'h3F_FFFF};
      @(posedge clk);
      #1;
    end
    s_en   = 1'b0;
    s_data = 32'hDEAD_BEEF;
  endtask

  task automatic load_large(input int pattern, input int stall_row);
    for (int r = 0; r < LR; r++) begin
      for (int w = 0; w < LWPR; w++) begin
        if (r == stall_row && w == 1) begin
          l_en   = 1'b0;
          l_data = 32'hFFFF_FFFF;
          repeat (3) @(posedge clk);
          #1;
        end
        l_en   = 1'b1;
        l_data = large_word(pattern, r, w);
        @(posedge clk);
        #1;
      end
    end
    l_en   = 1'b0;
    l_data = '0;
  endtask

  task automatic wait_small(output int n);
    n = 0;
    while (!s_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_large(output int n);
    n = 0;
    while (!l_done && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    small_rows[0] = 10'b0011011110;
    small_rows[1] = 10'b1110101011;
    small_rows[2] = 10'b1111101011;
    small_rows[3] = 10'b1011110010;
    small_rows[4] = 10'b1101111011;
    small_rows[5] = 10'b0111111101;
    small_rows[6] = 10'b0101010111;
    small_rows[7] = 10'b1011101111;
    small_rows[8] = 10'b0111111110;
    small_rows[9] = 10'b1010111010;

    do_reset();
    check("reset_s_sum",  32'(s_sum),  32'd0);
    check("reset_s_done", 32'(s_done), 32'd0);
    check("reset_l_sum",  32'(l_sum),  32'd0);
    check("reset_l_done", 32'(l_done), 32'd0);

    // 10x10 worked example
    load_small();
    check("small_done_after_load", 32'(s_done), 32'd0);
    wait_small(ncyc);
    check("small_done", 32'(s_done), 32'd1);
    check("small_sum",  32'(s_sum),  32'd43);
    s_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = $urandom;
      @(posedge clk);
      #1;
    end
    s_en = 1'b0;
    check("small_hold_sum",  32'(s_sum),  32'd43);
    check("small_hold_done", 32'(s_done), 32'd1);

    // empty grid: one pass of ROW_SIZE+1 cycles
    do_reset();
    load_large(0, -1);
    check("empty_done_after_load", 32'(l_done), 32'd0);
    wait_large(ncyc);
    check("empty_cycles", 32'(ncyc),   32'd140);
    check("empty_done",   32'(l_done), 32'd1);
    check("empty_sum",    32'(l_sum),  32'd0);

    // full grid: only corners go, second pass is clean
    do_reset();
    load_large(1, -1);
    wait_large(ncyc);
    check("ones_cycles", 32'(ncyc),  32'd280);
    check("ones_sum",    32'(l_sum), 32'd4);

    // isolated 2x2 block
    do_reset();
    load_large(2, -1);
    wait_large(ncyc);
    check("block_cycles", 32'(ncyc),  32'd280);
    check("block_sum",    32'(l_sum), 32'd4);

    // same block with a 3-cycle stall inside row 50
    do_reset();
    load_large(2, 50);
    wait_large(ncyc);
    check("stall_cycles", 32'(ncyc),  32'd280);
    check("stall_sum",    32'(l_sum), 32'd4);

    // abort mid-scan, then reload from scratch
    do_reset();
    load_small();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_sum",  32'(s_sum),  32'd0);
    check("abort_done", 32'(s_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    load_small();
    wait_small(ncyc);
    check("reload_done", 32'(s_done), 32'd1);
    check("reload_sum",  32'(s_sum),  32'd43);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/puzzle4_part2.md
Name: puzzle4_part2

Overview:
- Solves the iterative "accessible paper roll" grid puzzle. The grid is square, ROW_SIZE x ROW_SIZE bits, where 1 = roll.
- A roll is removable when fewer than 4 of its 8 neighbours are rolls.
- Removal repeats until no further roll is removable; the block reports the total number of rolls removed.
- The grid arrives as a word stream from the top level: MODULAR_SIZE bits per cycle, rows zero-padded to a whole number of words.

Parameters:
- ROW_SIZE, 139, grid width = grid height (number of rows) in cells.
- MODULAR_SIZE, 32, input word width.
- OUTPUT_WIDTH, 16, width of the removed-roll counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- top_enable  input  1  stream-valid; a word is accepted on each rising edge where it is high while in LOAD.
- in_data_top  input  MODULAR_SIZE  grid word, MSB first.
- out_sum  output  OUTPUT_WIDTH  running total of removed rolls; final when done=1.
- done  output  1  high once the grid is stable; holds until reset.

Behaviour:
- Derived constants:
  - WORDS_PER_ROW = ceil(ROW_SIZE/MODULAR_SIZE); 5 for the defaults.
  - PADDED = WORDS_PER_ROW*MODULAR_SIZE.
- Input mapping:
  - Word w of row r carries padded-row bits [PADDED-1-w*MODULAR_SIZE -: MODULAR_SIZE].
  - Padded bit PADDED-1 is column 0; column c is padded bit PADDED-1-c.
  - Bits for columns >= ROW_SIZE are discarded.
- Storage: grid held in ROW_SIZE registers of ROW_SIZE bits each.
- Reset (reset=0, asynchronous):
  - State goes to LOAD; out_sum=0; done=0; word and row counters=0; grid cleared.
  - Reset mid-operation aborts immediately, and the next load starts from row 0, word 0.
- LOAD:
  - Each edge with top_enable=1 stores one word and advances word, then row (row-major).
  - top_enable=0 stalls with no state change.
  - After word WORDS_PER_ROW-1 of row ROW_SIZE-1 is stored, go to SCAN.
- SCAN (one row per cycle, r = 0..ROW_SIZE-1):
  - For each column c with grid[r][c]=1, count set cells among the 8 neighbours. Neighbours come from rows r-1, r, r+1 and columns c-1, c+1; cells outside the grid count as 0.
  - mask = grid[r] & (count<4).
  - Write grid[r] <= grid[r] & ~mask.
  - out_sum += popcount(mask), modulo 2^OUTPUT_WIDTH.
  - Set the pass_changed flag if mask != 0.
  - Row r-1 may already be updated in the same pass. This is permitted: removal is monotone, so the final count is order-independent.
  - After row ROW_SIZE-1, go to CHECK.
- CHECK (1 cycle):
  - If pass_changed: clear the flag, set r=0, return to SCAN.
  - Otherwise go to DONE.
- DONE:
  - done=1; out_sum holds its value.
  - top_enable and in_data_top are ignored until reset.
- Latency:
  - Load takes ROW_SIZE*WORDS_PER_ROW enabled cycles.
  - Each pass then takes ROW_SIZE+1 cycles.
  - done asserts in the cycle after the first CHECK that sees no change.
- Arithmetic:
  - Neighbour counts are 4 bits.
  - Per-row popcount is ceil(log2(ROW_SIZE+1)) bits.
  - The accumulator wraps at OUTPUT_WIDTH bits; no overflow occurs for the defaults (max 19321).
- Boundaries:
  - An empty grid gives a single pass with no change, then done with out_sum=0.
  - Edge and corner cells use zero padding outside the grid.

Decomposition:
- Package puzzle4_pkg holds:
  - The WORDS_PER_ROW / PADDED helper functions.
  - The state enum {LOAD, SCAN, CHECK, DONE}.
  - The neighbour threshold constant (4).
- Sub-module row_remover (combinational):
  - Inputs: row_above, row_cur, row_below (ROW_SIZE bits each).
  - Outputs: new_row and removed_count.
- The top level holds the grid registers, counters, FSM and accumulator.

Test Plan:
- ROW_SIZE=10, MODULAR_SIZE=32, each row in the top 10 bits of one word. Grid rows:
  - ..@@.@@@@.
  - @@@.@.@.@@
  - @@@@@.@.@@
  - @.@@@@..@.
  - @@.@@@@.@@
  - .@@@@@@@.@
  - .@.@.@.@@@
  - @.@@@.@@@@
  - .@@@@@@@@.
  - @.@.@@@.@.
  - Expected: out_sum=43, then done=1.
- Defaults, all-zero 139x139 grid (695 words) -> done after one pass, out_sum=0.
- Defaults, all-ones grid (only the padding bits are 0) -> only the four corners are removed; out_sum=4.
- Defaults, 2x2 block of ones at rows 50-51, cols 60-61, rest zero -> out_sum=4; done after the second pass.
- Defaults, top_enable deasserted for 3 cycles mid-row -> no words lost; result identical to the uninterrupted case.
- Assert reset low during SCAN of the 10x10 case, release, reload the same grid -> out_sum=0 and done=0 during reset; final out_sum=43.
